// File: rtl/reg_ctrl_seq.sv
// reg_ctrl_seq: turns WRITE/INC/CLEAR micro-ops into single-cycle register strobes and reports completion.
// Optional build macro REG_CTRL_READBACK_EN adds a dout-vs-expected check reported on Err.
module reg_ctrl_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             RSTn,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdData,
  output logic             Wen,
  output logic             INC,
  output logic             RST,
  output logic [WIDTH-1:0] BusOut,
  input  logic [WIDTH-1:0] dout,
  output logic             Done,
  output logic             Err
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_started;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_bus;
  logic             w_accept;
  logic             w_needs_issue;
  logic             w_last_strobe;
  logic             w_err;

  assign w_accept      = CmdValid & CmdReady;
  assign w_needs_issue = (CmdOp == OP_WRITE) | (CmdOp == OP_CLEAR) |
                         ((CmdOp == OP_INC) & (CmdData != '0));
  // r_cnt holds the strobes still owed, including the current one
  assign w_last_strobe = (r_op != OP_INC) | (r_cnt <= WIDTH'(1));
  assign BusOut        = r_bus;

  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_needs_issue ? S_ISSUE : S_SETTLE;
        end
      end
      S_ISSUE: begin
        if (w_last_strobe) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: w_state_next = S_CHECK;
      S_CHECK:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    CmdReady = 1'b0;
    Wen      = 1'b0;
    INC      = 1'b0;
    RST      = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    case (r_state)
      S_IDLE: CmdReady = r_started;
      S_ISSUE: begin
        case (r_op)
          OP_WRITE: Wen = 1'b1;
          OP_INC:   INC = 1'b1;
          OP_CLEAR: RST = 1'b1;
          default:  ;
        endcase
      end
      S_CHECK: begin
        Done = 1'b1;
        Err  = w_err;
      end
      default: ;
    endcase
  end

  // r_started keeps CmdReady low until the first edge after reset release
  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      r_started <= 1'b0;
      r_op      <= OP_NOP;
      r_cnt     <= '0;
      r_bus     <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        r_op <= CmdOp;
        if (CmdOp == OP_INC) begin
          r_cnt <= CmdData;
        end
        if (CmdOp == OP_WRITE) begin
          r_bus <= CmdData;
        end
      end else if ((r_state == S_ISSUE) && (r_op == OP_INC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - WIDTH'(1);
      end
    end
  end

`ifdef REG_CTRL_READBACK_EN
  logic [WIDTH-1:0] r_expected;
  logic             r_mismatch;

  // INC expectation is relative to the register value seen at accept
  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      r_expected <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (w_accept) begin
        case (CmdOp)
          OP_WRITE: r_expected <= CmdData;
          OP_INC:   r_expected <= dout + CmdData;
          default:  r_expected <= '0;
        endcase
      end
      if (r_state == S_SETTLE) begin
        r_mismatch <= (r_op != OP_NOP) && (dout != r_expected);
      end
    end
  end

  assign w_err = r_mismatch;
`else
  logic w_unused_dout;

  assign w_unused_dout = ^dout;
  assign w_err         = 1'b0;
`endif

endmodule

// File: tb/tb_reg_ctrl_seq.sv
// Bench for reg_ctrl_seq: a simple register model closes the loop; a cycle-level command model checks every output.
`timescale 1ns/1ps
module tb_reg_ctrl_seq;

`ifdef REG_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       RSTn = 1'b0;
  logic       CmdValid = 1'b0;
  logic [1:0] CmdOp = 2'b00;
  logic [7:0] CmdData = 8'd0;
  logic       CmdReady, Wen, INC, RST, Done, Err;
  logic [7:0] BusOut, dout;
  logic [7:0] reg_q = 8'd0;
  logic       fault = 1'b0;

  int checks = 0;
  int errors = 0;

  // behavioural model of the command in flight
  bit   m_started = 0;
  bit   m_active = 0;
  int   m_k = 0;
  int   m_lat = 0;
  int   m_n = 0;
  int   m_op = 0;
  bit   m_err = 0;
  int   m_bus = 0;
  int   m_exp_val = 0;
  int   m_final = 0;

  always #5 Clk = ~Clk;

  reg_ctrl_seq #(.WIDTH(8)) dut (
    .Clk(Clk), .RSTn(RSTn), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .Wen(Wen), .INC(INC), .RST(RST),
    .BusOut(BusOut), .dout(dout), .Done(Done), .Err(Err)
  );

  // register being controlled; fault forces a stuck readback
  always @(posedge Clk) begin
    if (RST) reg_q <= 8'd0;
    else if (Wen) reg_q <= BusOut;
    else if (INC) reg_q <= reg_q + 8'd1;
  end
  assign dout = fault ? 8'd5 : reg_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      if (!RSTn) begin
        m_started = 0;
        m_active  = 0;
        m_bus     = 0;
      end else begin
        if (m_active) begin
          m_k++;
          if (m_k > m_lat) m_active = 0;
        end else if (m_started && CmdValid) begin
          m_active = 1;
          m_k      = 1;
          m_op     = int'(CmdOp);
          m_n      = int'(CmdData);
          case (m_op)
            1: begin m_lat = 3; m_exp_val = m_n; m_bus = m_n; end
            2: begin m_lat = (m_n == 0) ? 2 : m_n + 2; m_exp_val = (int'(dout) + m_n) % 256; end
            3: begin m_lat = 3; m_exp_val = 0; end
            default: begin m_lat = 2; m_exp_val = 0; end
          endcase
          m_final = fault ? 5 : m_exp_val;
          m_err   = RB && (m_op != 0) && (m_final != m_exp_val);
        end
        m_started = 1;
      end
      @(negedge Clk);
      if (!RSTn) begin
        chk("mon_ready", int'(CmdReady), 0);
        chk("mon_wen", int'(Wen), 0);
        chk("mon_inc", int'(INC), 0);
        chk("mon_rst", int'(RST), 0);
        chk("mon_bus", int'(BusOut), 0);
        chk("mon_done", int'(Done), 0);
        chk("mon_err", int'(Err), 0);
      end else begin
        chk("mon_ready", int'(CmdReady), int'(m_started && !m_active));
        chk("mon_wen", int'(Wen), int'(m_active && m_op == 1 && m_k == 1));
        chk("mon_inc", int'(INC), int'(m_active && m_op == 2 && m_k >= 1 && m_k <= m_n));
        chk("mon_rst", int'(RST), int'(m_active && m_op == 3 && m_k == 1));
        chk("mon_bus", int'(BusOut), m_bus);
        chk("mon_done", int'(Done), int'(m_active && m_k == m_lat));
        chk("mon_err", int'(Err), int'(m_active && m_k == m_lat && m_err));
      end
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [7:0] data, input bit hold,
                     input int exp_lat, output int err_at_done);
    int t;
    int lat;
    bit seen;
    @(negedge Clk); #1;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    t = 0;
    while (!CmdReady && t < 50) begin
      @(negedge Clk); #1;
      t++;
    end
    err_at_done = -1;
    if (!CmdReady) begin
      chk("accept_timeout", 0, 1);
      CmdValid = 1'b0;
    end else begin
      @(posedge Clk);
      lat  = 0;
      seen = 0;
      while (!seen && lat < 300) begin
        @(negedge Clk);
        lat++;
        if (!hold) begin
          CmdValid = 1'b0;
          CmdOp    = 2'($urandom_range(0, 3));
          CmdData  = 8'($urandom_range(0, 255));
        end
        if (Done) begin
          seen = 1;
          err_at_done = int'(Err);
        end
      end
      CmdValid = 1'b0;
      chk("latency", lat, exp_lat);
      $display("cmd op=%0d data=%0d latency=%0d err=%0d reg=%0d", op, data, lat, err_at_done, reg_q);
    end
  endtask

  initial begin
    int e;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_ready", int'(CmdReady), 0);
    chk("reset_bus", int'(BusOut), 0);
    @(negedge Clk); #1;
    RSTn = 1'b1;
    #1 chk("ready_before_edge", int'(CmdReady), 0);
    @(posedge Clk); #1;
    chk("ready_first_edge", int'(CmdReady), 1);

    cmd(2'b01, 8'd67, 0, 3, e);
    chk("write67_reg", int'(reg_q), 67);
    chk("write67_err", e, 0);
    chk("write67_bus", int'(BusOut), 67);

    cmd(2'b10, 8'd3, 0, 5, e);
    chk("inc3_reg", int'(reg_q), 70);
    chk("inc3_err", e, 0);

    cmd(2'b11, 8'd0, 1, 3, e);
    chk("clear_reg", int'(reg_q), 0);
    chk("clear_err", e, 0);

    cmd(2'b01, 8'd255, 0, 3, e);
    cmd(2'b10, 8'd2, 0, 4, e);
    chk("wrap_reg", int'(reg_q), 1);
    chk("wrap_err", e, 0);

    cmd(2'b10, 8'd0, 0, 2, e);
    chk("inc0_reg", int'(reg_q), 1);
    cmd(2'b00, 8'hAA, 0, 2, e);
    chk("nop_err", e, 0);
    chk("nop_bus", int'(BusOut), 255);

    @(negedge Clk);
    fault = 1'b1;
    cmd(2'b01, 8'd9, 0, 3, e);
    chk("fault_err", e, int'(RB));
    @(negedge Clk);
    fault = 1'b0;
    chk("fault_reg", int'(reg_q), 9);

    // INC 5 interrupted by reset in its second cycle
    @(negedge Clk); #1;
    CmdValid = 1'b1;
    CmdOp    = 2'b10;
    CmdData  = 8'd5;
    @(posedge Clk);
    @(negedge Clk);
    CmdValid = 1'b0;
    chk("abort_inc_c1", int'(INC), 1);
    @(posedge Clk); #2;
    RSTn = 1'b0;
    #1;
    chk("abort_inc", int'(INC), 0);
    chk("abort_wen", int'(Wen), 0);
    chk("abort_rst", int'(RST), 0);
    chk("abort_done", int'(Done), 0);
    chk("abort_ready", int'(CmdReady), 0);
    chk("abort_bus", int'(BusOut), 0);
    repeat (2) @(negedge Clk);
    #1 RSTn = 1'b1;
    #1 chk("abort_ready_rel", int'(CmdReady), 0);
    @(posedge Clk); #1;
    chk("abort_ready_edge", int'(CmdReady), 1);
    chk("abort_partial_reg", int'(reg_q), 10);
    repeat (6) @(negedge Clk);

    cmd(2'b01, 8'h5A, 0, 3, e);
    chk("recover_reg", int'(reg_q), 90);
    cmd(2'b10, 8'd170, 0, 172, e);
    chk("bigwrap_reg", int'(reg_q), 4);
    chk("bigwrap_err", e, 0);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
